// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: access-size codes, FSM states and
// the store byte-enable helper used by mem_wb_stage_p.
package mem_wb_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Size code 2'b11 behaves like a word access.
   function automatic logic [3:0] storeEnables(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b1111;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_be.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are not touched by any reset.
module dmem_be #(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic [3:0]        i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge Clk) begin
      for (int n = 0; n < 4; n++) begin
         if (i_be[n]) begin
            r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
         end
      end
   end

   // Read returns pre-write contents, so a load never sees its own cycle's store.
   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage_p.sv
// MEM/WB pipeline stage with wait-stated data memory and byte/half/word lanes.
// Define MEM_WB_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_wb_stage_p
   import mem_wb_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              MemtoReg,
   input  logic              RegWrite,
   input  logic [1:0]        MemSize,
   input  logic              MemSigned,
   input  logic [DATA_W-1:0] AlUResult,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [4:0]        WriteReg,
   output logic              Stall,
   output logic              WBValid,
   output logic              WBRegWrite,
   output logic [4:0]        WBWriteReg,
   output logic [DATA_W-1:0] WriteDataReg,
   output logic              MisalignErr
);

   localparam bit         HAS_WAIT = (WAIT_STATES > 0);
   localparam logic [2:0] LAST_CNT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t      r_state;
   state_t      w_stateNext;
   logic [2:0]  r_waitCnt;
   logic [2:0]  w_cntNext;

   logic        r_wbValid;
   logic        r_wbRegWrite;
   logic [4:0]  r_wbWriteReg;
   logic [31:0] r_writeData;
   logic        r_misalignErr;

   logic        w_memOp;
   logic        w_isLoad;
   logic        w_fire;
   logic        w_misalign;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [3:0]  w_memBe;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_loadData;
   logic        w_unusedAddrBits;

   assign w_memOp  = MemRead | MemWrite;
   assign w_isLoad = MemRead & ~MemWrite;
   assign w_lane   = AlUResult[1:0];
   assign w_fire   = InValid & ~Stall;

   assign w_unusedAddrBits = ^AlUResult[DATA_W-1:ADDR_W+2];

`ifdef MEM_WB_MISALIGN_TRAP_EN
   always_comb begin
      w_misalign = 1'b0;
      if (w_memOp) begin
         case (MemSize)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = w_lane[0];
            default: w_misalign = (w_lane != 2'b00);
         endcase
      end
   end
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= ST_IDLE;
         r_waitCnt <= 3'd0;
      end else begin
         r_state   <= w_stateNext;
         r_waitCnt <= w_cntNext;
      end
   end

   // Stall holds the op at the input until the last wait cycle, where it is accepted.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_waitCnt;
      Stall       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (HAS_WAIT && InValid && w_memOp) begin
               Stall       = 1'b1;
               w_stateNext = ST_WAIT;
               w_cntNext   = 3'd0;
            end
         end
         ST_WAIT: begin
            if (r_waitCnt == LAST_CNT) begin
               w_stateNext = ST_IDLE;
               w_cntNext   = 3'd0;
            end else begin
               Stall     = 1'b1;
               w_cntNext = r_waitCnt + 3'd1;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_cntNext   = 3'd0;
         end
      endcase
      if (Reset) begin
         Stall = 1'b0;
      end
   end

   always_comb begin
      w_be    = storeEnables(MemSize, w_lane);
      w_wdata = ReadData2;
      case (MemSize)
         SZ_BYTE: w_wdata = {4{ReadData2[7:0]}};
         SZ_HALF: w_wdata = {2{ReadData2[15:0]}};
         default: w_wdata = ReadData2;
      endcase
   end

   // Reset on the accepting edge aborts the store before it reaches memory.
   assign w_memBe = (w_fire && MemWrite && !w_misalign && !Reset) ? w_be : 4'b0000;

   dmem_be #(
      .ADDR_W(ADDR_W)
   ) u_dmem (
      .Clk    (Clk),
      .i_be   (w_memBe),
      .i_addr (AlUResult[ADDR_W+1:2]),
      .i_wdata(w_wdata),
      .o_rdata(w_rdata)
   );

   assign w_byte = w_rdata[{w_lane, 3'b000} +: 8];
   assign w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

   always_comb begin
      w_loadData = w_rdata;
      case (MemSize)
         SZ_BYTE: w_loadData = {{24{MemSigned & w_byte[7]}}, w_byte};
         SZ_HALF: w_loadData = {{16{MemSigned & w_half[15]}}, w_half};
         default: w_loadData = w_rdata;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_wbValid     <= 1'b0;
         r_wbRegWrite  <= 1'b0;
         r_wbWriteReg  <= 5'd0;
         r_writeData   <= 32'd0;
         r_misalignErr <= 1'b0;
      end else begin
         r_wbValid     <= w_fire;
         r_wbRegWrite  <= w_fire & RegWrite & ~MemWrite & ~w_misalign;
         r_misalignErr <= w_fire & w_misalign;
         if (w_fire) begin
            r_wbWriteReg <= WriteReg;
            r_writeData  <= (w_isLoad && MemtoReg && !w_misalign) ? w_loadData : AlUResult;
         end
      end
   end

   assign WBValid      = r_wbValid;
   assign WBRegWrite   = r_wbRegWrite;
   assign WBWriteReg   = r_wbWriteReg;
   assign WriteDataReg = r_writeData;
   assign MisalignErr  = r_misalignErr;

endmodule
